asic_axi_feeder_master: RTL and testbench
=========================================

Name: asic_axi_feeder_master

Overview:
AXI4 master that drives the ASIC wrapper's MMIO slave port from the host side. It turns a command into one of two transactions:
- Write-stream: a word stream is pushed into a single MMIO register, such as the ASIC data port, using FIXED bursts.
- Single read: one word is read from a register, such as the ofmap, and returned to the requester.
It sits between the controller/DMA logic and the AXI interconnect slave port of the ASIC wrapper.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (WSTRB width is DATA_W/8)
ID_W, 4, AXI ID width
LEN_W, 4, AXI burst length field width
MAX_BURST, 16, max beats per write burst (must be <= 2**LEN_W)
CNT_W, 11, width of word-count field (max 2047 words)
MASTER_ID, 0, constant AWID/ARID value

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write-stream, 0 = single read
cmd_addr  in  ADDR_W  target MMIO address
cmd_words  in  CNT_W  words to write (ignored for read)
s_data  in  DATA_W  write-stream data
s_valid  in  1  stream valid
s_ready  out  1  stream ready
rd_data  out  DATA_W  read result, held until next read
rd_valid  out  1  one-cycle pulse with rd_data
done  out  1  one-cycle pulse at command end
err  out  1  set by non-OKAY response, cleared on next cmd accept
busy  out  1  state != IDLE
AWID_M/AWADDR_M/AWLEN_M/AWSIZE_M/AWBURST_M/AWVALID_M  out; AWREADY_M  in
WDATA_M/WSTRB_M/WLAST_M/WVALID_M  out; WREADY_M  in
BID_M/BRESP_M/BVALID_M  in; BREADY_M  out
ARID_M/ARADDR_M/ARLEN_M/ARSIZE_M/ARBURST_M/ARVALID_M  out; ARREADY_M  in
RID_M/RDATA_M/RRESP_M/RLAST_M/RVALID_M  in; RREADY_M  out

Behaviour:
- Reset: ARESETn, synchronous, active-low; clock ACLK. While in reset and on the cycle after release:
  - all *VALID_M, BREADY_M, RREADY_M, s_ready, rd_valid, done, err, busy are 0;
  - cmd_ready is 1; rd_data is 0.
  - Reset asserted mid-operation returns to IDLE on the next edge and abandons the transaction.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_valid && cmd_ready latches addr, words and type, and clears err.
  - Next state: AW if write with words > 0; DONE if write with words == 0 (no AXI traffic); AR if read.
  - AWVALID_M/ARVALID_M rise the cycle after acceptance.
- AW:
  - AWVALID_M=1; AWADDR_M=latched addr (unchanged every burst); AWBURST_M=FIXED (2'b00); AWSIZE_M=3'b010; AWID_M=MASTER_ID.
  - AWLEN_M=min(remaining, MAX_BURST)-1, computed at AW entry and stable while AWVALID_M is high.
  - On AWREADY_M go to W.
- W:
  - WVALID_M=s_valid; s_ready=WREADY_M; WDATA_M=s_data; WSTRB_M all ones.
  - Beat counter increments on each WVALID_M && WREADY_M. WLAST_M=1 when beat == AWLEN_M.
  - The last-beat handshake goes to B.
  - Upstream holds s_valid and s_data stable until s_ready (AXI valid rule); the bench asserts this.
  - s_ready is 0 in every state other than W.
- B:
  - BREADY_M=1. On BVALID_M, remaining -= burst length.
  - BRESP_M != OKAY: set err and go to DONE, aborting the remaining words.
  - Else go to DONE if remaining == 0, otherwise back to AW.
- AR:
  - ARVALID_M=1; ARADDR_M=latched addr; ARLEN_M=0; ARSIZE_M=3'b010; ARBURST_M=INCR.
  - On ARREADY_M go to R.
- R:
  - RREADY_M=1. On RVALID_M: capture RDATA_M into rd_data and pulse rd_valid the following cycle (same cycle as done).
  - Set err if RRESP_M != OKAY. Go to DONE.
  - There is no timeout: the slave withholds RVALID until its ofmap is valid.
- DONE: done=1 for one cycle, then IDLE. cmd_ready=0 during DONE.
- AW and W never overlap; W starts only after the AW handshake. One outstanding transaction only.
- Width rules:
  - remaining is CNT_W bits and never underflows, since burst length <= remaining.
  - Beat counter is LEN_W bits.

Decomposition:
- Shared package asic_axi_pkg holds:
  - AXI width macros/constants;
  - RESP codes (OKAY=2'b00, SLVERR=2'b10);
  - BURST_FIXED/BURST_INCR;
  - SIZE_4B;
  - ASIC register offsets (ENABLE 0x0, DATA 0x4, OFMAP 0x8);
  - the FSM state enum.
- Single module; no sub-module needed.

Test Plan:
1. Write cmd, addr 0x4, words 1104, stream 0..1103 with WREADY always 1 -> 69 bursts, each with AWLEN=15, AWBURST=00, AWADDR=0x4. WLAST on every 16th beat; data in order; done after the 69th B; err=0.
2. Write cmd, words 20 -> two bursts with AWLEN=15 then AWLEN=3; 20 W beats; done once.
3. Write cmd, words 40, first BRESP=SLVERR -> no second AWVALID, done pulse, err=1. Next cmd accept clears err.
4. Read cmd, addr 0x8; slave holds RVALID low for 50 cycles, then RDATA=0xDEADBEEF -> rd_valid pulse with rd_data=0xDEADBEEF, done in the same cycle, err=0.
5. Random s_valid gaps and WREADY backpressure on a 37-word write -> exactly 37 beats, no duplicates or drops, WVALID_M never drops without a handshake.
6. ARESETn low during beat 5 of a burst -> all VALIDs 0 and cmd_ready=1 after the edge. Write with words 0 -> done the cycle after accept, with no AW/W traffic.

Source files
------------

// File: rtl/asic_axi_pkg.sv
// Shared AXI constants, ASIC register map and feeder FSM state encoding.
package asic_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam logic [31:0] REG_ENABLE = 32'h0;
  localparam logic [31:0] REG_DATA   = 32'h4;
  localparam logic [31:0] REG_OFMAP  = 32'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/asic_axi_feeder_master_if.sv
// AXI4 master-side bundle between the feeder and the ASIC wrapper MMIO port.
interface asic_axi_feeder_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]     AWID_M;
  logic [ADDR_W-1:0]   AWADDR_M;
  logic [LEN_W-1:0]    AWLEN_M;
  logic [2:0]          AWSIZE_M;
  logic [1:0]          AWBURST_M;
  logic                AWVALID_M;
  logic                AWREADY_M;
  logic [DATA_W-1:0]   WDATA_M;
  logic [DATA_W/8-1:0] WSTRB_M;
  logic                WLAST_M;
  logic                WVALID_M;
  logic                WREADY_M;
  logic [ID_W-1:0]     BID_M;
  logic [1:0]          BRESP_M;
  logic                BVALID_M;
  logic                BREADY_M;
  logic [ID_W-1:0]     ARID_M;
  logic [ADDR_W-1:0]   ARADDR_M;
  logic [LEN_W-1:0]    ARLEN_M;
  logic [2:0]          ARSIZE_M;
  logic [1:0]          ARBURST_M;
  logic                ARVALID_M;
  logic                ARREADY_M;
  logic [ID_W-1:0]     RID_M;
  logic [DATA_W-1:0]   RDATA_M;
  logic [1:0]          RRESP_M;
  logic                RLAST_M;
  logic                RVALID_M;
  logic                RREADY_M;

  modport master (
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  AWREADY_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    input  WREADY_M,
    input  BID_M, BRESP_M, BVALID_M,
    output BREADY_M,
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M
  );

  modport slave (
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output AWREADY_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    output WREADY_M,
    output BID_M, BRESP_M, BVALID_M,
    input  BREADY_M,
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M
  );
endinterface

// File: rtl/asic_axi_feeder_master.sv
// AXI4 master feeding the ASIC MMIO port: FIXED-burst word streams into one
// register, or a single-word read returned to the requester.
module asic_axi_feeder_master
  import asic_axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 11,
  parameter int MASTER_ID = 0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_words,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              busy,
  asic_axi_feeder_master_if.master axi
);

  localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

  feeder_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  beat_q;
  logic              err_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [CNT_W-1:0]  burst_len;
  logic [LEN_W-1:0]  awlen;
  logic              wlast;
  logic              w_hs;
  logic              unused_ids;

  // remaining only changes on the B handshake, so the burst length derived
  // from it stays stable across AW, W and B of the same burst.
  assign burst_len = (remaining_q > MAX_BURST_C) ? MAX_BURST_C : remaining_q;
  assign awlen     = LEN_W'(burst_len - CNT_W'(1));
  assign wlast     = (beat_q == awlen);
  assign w_hs      = (state_q == ST_W) && s_valid && axi.WREADY_M;

  assign axi.AWID_M    = ID_W'(MASTER_ID);
  assign axi.AWADDR_M  = addr_q;
  assign axi.AWLEN_M   = awlen;
  assign axi.AWSIZE_M  = SIZE_4B;
  assign axi.AWBURST_M = BURST_FIXED;
  assign axi.WDATA_M   = s_data;
  assign axi.WSTRB_M   = '1;
  assign axi.WLAST_M   = (state_q == ST_W) && wlast;
  assign axi.ARID_M    = ID_W'(MASTER_ID);
  assign axi.ARADDR_M  = addr_q;
  assign axi.ARLEN_M   = '0;
  assign axi.ARSIZE_M  = SIZE_4B;
  assign axi.ARBURST_M = BURST_INCR;

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign err        = err_q;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign unused_ids = ^{axi.BID_M, axi.RID_M, axi.RLAST_M};

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and channel handshake outputs.
  always_comb begin
    state_d        = state_q;
    cmd_ready      = 1'b0;
    s_ready        = 1'b0;
    axi.AWVALID_M  = 1'b0;
    axi.WVALID_M   = 1'b0;
    axi.BREADY_M   = 1'b0;
    axi.ARVALID_M  = 1'b0;
    axi.RREADY_M   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!cmd_write)            state_d = ST_AR;
          else if (cmd_words == '0)  state_d = ST_DONE;
          else                       state_d = ST_AW;
        end
      end
      ST_AW: begin
        axi.AWVALID_M = 1'b1;
        if (axi.AWREADY_M) state_d = ST_W;
      end
      ST_W: begin
        axi.WVALID_M = s_valid;
        s_ready      = axi.WREADY_M;
        if (w_hs && wlast) state_d = ST_B;
      end
      ST_B: begin
        axi.BREADY_M = 1'b1;
        if (axi.BVALID_M) begin
          if (axi.BRESP_M != RESP_OKAY)     state_d = ST_DONE;
          else if (remaining_q == burst_len) state_d = ST_DONE;
          else                               state_d = ST_AW;
        end
      end
      ST_AR: begin
        axi.ARVALID_M = 1'b1;
        if (axi.ARREADY_M) state_d = ST_R;
      end
      ST_R: begin
        axi.RREADY_M = 1'b1;
        if (axi.RVALID_M) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch and burst bookkeeping; meaningless outside a command.
  always_ff @(posedge ACLK) begin
    if (state_q == ST_IDLE && cmd_valid) begin
      addr_q      <= cmd_addr;
      remaining_q <= cmd_words;
    end else if (state_q == ST_B && axi.BVALID_M) begin
      remaining_q <= remaining_q - burst_len;
    end
  end

  // Beat counter, error flag and read-return registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      beat_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (state_q == ST_IDLE && cmd_valid) begin
        err_q  <= 1'b0;
        beat_q <= '0;
      end
      if (w_hs) beat_q <= wlast ? '0 : beat_q + LEN_W'(1);
      if (state_q == ST_B && axi.BVALID_M && axi.BRESP_M != RESP_OKAY) err_q <= 1'b1;
      if (state_q == ST_R && axi.RVALID_M) begin
        rd_data_q  <= axi.RDATA_M;
        rd_valid_q <= 1'b1;
        if (axi.RRESP_M != RESP_OKAY) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_asic_axi_feeder_master.sv
// Directed bench for asic_axi_feeder_master with an inline AXI slave model.
module tb_asic_axi_feeder_master;
  import asic_axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 11;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [CNT_W-1:0]  cmd_words = '0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, done, err, busy;

  int checks = 0;
  int errors = 0;

  int n_aw, n_w, n_b, n_done, n_overlap, n_drop, done_err;
  int aw_log [0:3];

  asic_axi_feeder_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) axi ();

  asic_axi_feeder_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W),
    .MAX_BURST(16), .CNT_W(CNT_W), .MASTER_ID(0)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .busy(busy),
    .axi(axi)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctl_vec();
    return {axi.AWVALID_M, axi.WVALID_M, axi.BREADY_M, axi.ARVALID_M, axi.RREADY_M,
            s_ready, rd_valid, done, err, busy};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  // Runs a write-stream command against the slave model. err_burst selects
  // which burst gets SLVERR (-1 none); abort_at returns after that many beats.
  task automatic do_write(input logic [31:0] addr, input int words, input int err_burst,
                          input bit rnd, input int abort_at);
    int  rem, cur_len, beat, w_idx, burst_idx;
    bit  pend_b, fin, prev_stall, hs_last, hold;
    rem = words; cur_len = 0; beat = 0; w_idx = 0; burst_idx = 0;
    pend_b = 0; fin = 0; prev_stall = 0; hs_last = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_done = 0; n_overlap = 0; n_drop = 0; done_err = 0;
    for (int i = 0; i < 4; i++) aw_log[i] = -1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_words = CNT_W'(words);
    tick();
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      if (abort_at >= 0 && w_idx == abort_at) return;
      axi.AWREADY_M = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.WREADY_M  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = s_valid && !hs_last;
      if (!hold) begin
        if (w_idx < words) begin
          s_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
          s_data  = DATA_W'(w_idx);
        end else begin
          s_valid = 1'b0;
        end
      end
      axi.BVALID_M = pend_b;
      axi.BRESP_M  = (burst_idx == err_burst) ? RESP_SLVERR : RESP_OKAY;
      #1;
      if (axi.AWVALID_M && axi.WVALID_M) n_overlap++;
      if (prev_stall && !axi.WVALID_M) n_drop++;
      prev_stall = axi.WVALID_M && !axi.WREADY_M;
      if (axi.AWVALID_M && axi.AWREADY_M) begin
        cur_len = ((rem > 16) ? 16 : rem) - 1;
        chk("awlen", 64'(axi.AWLEN_M), 64'(cur_len));
        chk("awaddr", 64'(axi.AWADDR_M), 64'(addr));
        chk("awburst_size", {59'd0, axi.AWBURST_M, axi.AWSIZE_M}, {59'd0, 2'b00, 3'b010});
        if (n_aw < 4) aw_log[n_aw] = int'(axi.AWLEN_M);
        n_aw++;
      end
      hs_last = 1'b0;
      if (axi.WVALID_M && axi.WREADY_M) begin
        chk("wdata", 64'(axi.WDATA_M), 64'(w_idx));
        chk("wlast", 64'(axi.WLAST_M), 64'(beat == cur_len));
        w_idx++; n_w++; hs_last = 1'b1;
        if (beat == cur_len) begin
          pend_b = 1'b1; beat = 0;
        end else begin
          beat++;
        end
      end
      if (axi.BVALID_M && axi.BREADY_M) begin
        n_b++; rem -= cur_len + 1; pend_b = 1'b0; burst_idx++;
      end
      if (done) begin
        n_done++; done_err = int'(err); fin = 1'b1;
      end
      tick();
    end
    s_valid = 1'b0;
    axi.BVALID_M = 1'b0;
    if (!fin) chk("write_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    axi.AWREADY_M = 1'b0; axi.WREADY_M = 1'b0;
    axi.BID_M = '0; axi.BRESP_M = RESP_OKAY; axi.BVALID_M = 1'b0;
    axi.ARREADY_M = 1'b0;
    axi.RID_M = '0; axi.RDATA_M = '0; axi.RRESP_M = RESP_OKAY;
    axi.RLAST_M = 1'b0; axi.RVALID_M = 1'b0;

    // Reset state, during reset and on the cycle after release.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_ctl", 64'(ctl_vec()), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    ARESETn = 1'b1;
    tick();
    chk("rel_ctl", 64'(ctl_vec()), 64'd0);
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rel_rd_data", 64'(rd_data), 64'd0);

    // 1104 words -> 69 full bursts.
    do_write(32'h4, 1104, -1, 1'b0, -1);
    chk("t1_aw", 64'(n_aw), 64'd69);
    chk("t1_w", 64'(n_w), 64'd1104);
    chk("t1_b", 64'(n_b), 64'd69);
    chk("t1_done", 64'(n_done), 64'd1);
    chk("t1_err", 64'(done_err), 64'd0);
    chk("t1_overlap", 64'(n_overlap), 64'd0);
    chk("t1_done_pulse", {62'd0, done, cmd_ready}, {62'd0, 1'b0, 1'b1});

    // 20 words -> AWLEN 15 then 3.
    do_write(32'h4, 20, -1, 1'b0, -1);
    chk("t2_awlen0", 64'(aw_log[0]), 64'd15);
    chk("t2_awlen1", 64'(aw_log[1]), 64'd3);
    chk("t2_aw", 64'(n_aw), 64'd2);
    chk("t2_w", 64'(n_w), 64'd20);
    chk("t2_done", 64'(n_done), 64'd1);

    // 40 words, first B is SLVERR -> abort after one burst.
    do_write(32'h4, 40, 0, 1'b0, -1);
    chk("t3_aw", 64'(n_aw), 64'd1);
    chk("t3_w", 64'(n_w), 64'd16);
    chk("t3_b", 64'(n_b), 64'd1);
    chk("t3_done", 64'(n_done), 64'd1);
    chk("t3_err_at_done", 64'(done_err), 64'd1);
    chk("t3_err_held", 64'(err), 64'd1);
    repeat (2) tick();
    chk("t3_no_aw", 64'(axi.AWVALID_M), 64'd0);

    // Read of OFMAP with a 50-cycle RVALID delay; accept also clears err.
    begin
      int early;
      early = 0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
      tick();
      cmd_valid = 1'b0;
      axi.ARREADY_M = 1'b1;
      #1;
      chk("t4_err_cleared", 64'(err), 64'd0);
      chk("t4_arvalid", 64'(axi.ARVALID_M), 64'd1);
      chk("t4_araddr", 64'(axi.ARADDR_M), 64'h8);
      chk("t4_ar_len_burst_size", {57'd0, axi.ARLEN_M, axi.ARBURST_M, axi.ARSIZE_M},
          {57'd0, 4'd0, 2'b01, 3'b010});
      tick();
      axi.ARREADY_M = 1'b0;
      for (int i = 0; i < 50; i++) begin
        #1;
        if (rd_valid || done || !axi.RREADY_M) early++;
        tick();
      end
      chk("t4_wait", 64'(early), 64'd0);
      axi.RVALID_M = 1'b1; axi.RDATA_M = 32'hDEADBEEF; axi.RRESP_M = RESP_OKAY;
      tick();
      axi.RVALID_M = 1'b0;
      #1;
      chk("t4_rd_valid_done", {62'd0, rd_valid, done}, {62'd0, 1'b1, 1'b1});
      chk("t4_rd_data", 64'(rd_data), 64'hDEADBEEF);
      chk("t4_err", 64'(err), 64'd0);
      tick();
      chk("t4_pulse_end", {62'd0, rd_valid, done}, 64'd0);
      chk("t4_rd_data_held", 64'(rd_data), 64'hDEADBEEF);
    end

    // 37 words under random stream gaps and WREADY/AWREADY backpressure.
    do_write(32'h4, 37, -1, 1'b1, -1);
    chk("t5_w", 64'(n_w), 64'd37);
    chk("t5_aw", 64'(n_aw), 64'd3);
    chk("t5_drop", 64'(n_drop), 64'd0);
    chk("t5_overlap", 64'(n_overlap), 64'd0);
    chk("t5_done", 64'(n_done), 64'd1);

    // Reset in the middle of a burst, then a zero-word write.
    do_write(32'h4, 40, -1, 1'b0, 5);
    chk("t6_mid_burst", {62'd0, axi.WVALID_M, busy}, {62'd0, 1'b1, 1'b1});
    ARESETn = 1'b0;
    tick();
    chk("t6_rst_ctl", 64'(ctl_vec()), 64'd0);
    chk("t6_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    s_valid = 1'b0;
    ARESETn = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_words = '0;
    #1;
    chk("t6_zero_accept", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("t6_zero_done", {61'd0, done, axi.AWVALID_M, axi.WVALID_M}, {61'd0, 1'b1, 1'b0, 1'b0});
    tick();
    chk("t6_zero_after", {61'd0, done, axi.AWVALID_M, cmd_ready}, {61'd0, 1'b0, 1'b0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
